// File: rtl/dbg_mem_pkg.sv
// dbg_mem_pkg: shared encodings for the debug memory master.
// Holds the command size encoding, the FSM state enum, the default bus
// timeout and the alignment check used when a command is accepted.
package dbg_mem_pkg;
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_BAD  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam int unsigned TIMEOUT_DEFAULT = 256;

    function automatic logic misaligned(input size_e size, input logic [1:0] lo);
        return (size == SZ_BAD) || (size == SZ_HALF && lo[0]) || (size == SZ_WORD && lo != 2'b00);
    endfunction
endpackage

// File: rtl/dbg_mem_lane.sv
// dbg_mem_lane: combinational byte-lane steering for the debug memory master.
// Ports: write/size/lo describe the access (lo = addr[1:0]); wdata is the
// right-justified write data; rdata_in is the raw bus word. Outputs are the
// bus write strobe, the lane-replicated write data and the right-justified,
// zero-extended read data.
module dbg_mem_lane
    import dbg_mem_pkg::*;
(
    input  logic        write,
    input  size_e       size,
    input  logic [1:0]  lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_in,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_out
);
    logic [31:0] shifted;

    always_comb begin
        wstrb     = !write ? 4'b0000 :
                    size == SZ_BYTE ? 4'b0001 << lo :
                    size == SZ_HALF ? 4'b0011 << lo :
                    size == SZ_WORD ? 4'b1111 : 4'b0000;
        wdata_rep = size == SZ_BYTE ? {4{wdata[7:0]}} :
                    size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
        shifted   = rdata_in >> {lo, 3'b000};
        rdata_out = size == SZ_BYTE ? {24'b0, shifted[7:0]} :
                    size == SZ_HALF ? {16'b0, shifted[15:0]} : shifted;
    end
endmodule

// File: rtl/dbg_mem_master.sv
// dbg_mem_master: turns single debug read/write commands into picorv32
// native-bus cycles with a bus timeout.
// Ports: cmd_* is the valid/ready command channel, resp_* the valid/ready
// response channel (rdata, err, timeout flag), mem_* the initiator side of
// the picorv32 memory bus. clk rising edge, resetn synchronous active-low.
module dbg_mem_master
    import dbg_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_size,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        resp_timeout,
    output logic        mem_valid,
    output logic        mem_instr,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    size_e       size_q, size_d;
    logic [1:0]  lo_q, lo_d;
    logic        write_q, write_d;
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic        resp_timeout_q, resp_timeout_d;
    logic        in_idle;
    logic [3:0]  lane_wstrb;
    logic [31:0] lane_wdata, lane_rdata;

    assign in_idle = state_q == S_IDLE;

    // One lane instance: fed from the live command while idle (to build
    // strobes/data), from the captured command during the bus cycle.
    dbg_mem_lane u_lane (
        .write     (cmd_write),
        .size      (in_idle ? size_e'(cmd_size) : size_q),
        .lo        (in_idle ? cmd_addr[1:0] : lo_q),
        .wdata     (cmd_wdata),
        .rdata_in  (mem_rdata),
        .wstrb     (lane_wstrb),
        .wdata_rep (lane_wdata),
        .rdata_out (lane_rdata)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        size_d         = size_q;
        lo_d           = lo_q;
        write_d        = write_q;
        mem_valid_d    = mem_valid_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_wstrb_d    = mem_wstrb_q;
        resp_rdata_d   = resp_rdata_q;
        resp_err_d     = resp_err_q;
        resp_timeout_d = resp_timeout_q;
        if (in_idle && cmd_valid) begin
            size_d  = size_e'(cmd_size);
            lo_d    = cmd_addr[1:0];
            write_d = cmd_write;
            cnt_d   = 16'd0;
            if (misaligned(size_e'(cmd_size), cmd_addr[1:0])) begin
                state_d        = S_RESP;
                resp_err_d     = 1'b1;
                resp_timeout_d = 1'b0;
                resp_rdata_d   = 32'd0;
            end else begin
                state_d     = S_BUS;
                mem_valid_d = 1'b1;
                mem_addr_d  = {cmd_addr[31:2], 2'b00};
                mem_wdata_d = lane_wdata;
                mem_wstrb_d = lane_wstrb;
            end
        end else if (state_q == S_BUS) begin
            // mem_ready wins over a timeout reached in the same cycle
            if (mem_ready) begin
                state_d        = S_RESP;
                mem_valid_d    = 1'b0;
                resp_err_d     = 1'b0;
                resp_timeout_d = 1'b0;
                resp_rdata_d   = write_q ? 32'd0 : lane_rdata;
            end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                state_d        = S_RESP;
                mem_valid_d    = 1'b0;
                resp_err_d     = 1'b1;
                resp_timeout_d = 1'b1;
                resp_rdata_d   = 32'd0;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end else if (state_q == S_RESP && resp_ready) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= S_IDLE;
            cnt_q          <= 16'd0;
            size_q         <= SZ_BYTE;
            lo_q           <= 2'b00;
            write_q        <= 1'b0;
            mem_valid_q    <= 1'b0;
            mem_addr_q     <= 32'd0;
            mem_wdata_q    <= 32'd0;
            mem_wstrb_q    <= 4'd0;
            resp_rdata_q   <= 32'd0;
            resp_err_q     <= 1'b0;
            resp_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            size_q         <= size_d;
            lo_q           <= lo_d;
            write_q        <= write_d;
            mem_valid_q    <= mem_valid_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_wstrb_q    <= mem_wstrb_d;
            resp_rdata_q   <= resp_rdata_d;
            resp_err_q     <= resp_err_d;
            resp_timeout_q <= resp_timeout_d;
        end
    end

    assign cmd_ready    = in_idle && resetn;
    assign resp_valid   = state_q == S_RESP;
    assign resp_rdata   = resp_rdata_q;
    assign resp_err     = resp_err_q;
    assign resp_timeout = resp_timeout_q;
    assign mem_valid    = mem_valid_q;
    assign mem_instr    = 1'b0;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_wstrb    = mem_wstrb_q;
endmodule

// File: tb/tb_dbg_mem_master.sv
// tb_dbg_mem_master: directed and randomized checks of dbg_mem_master against a byte-level memory model.
module tb_dbg_mem_master;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [1:0]  cmd_size = 2'd0;
    logic [31:0] cmd_addr = 32'd0, cmd_wdata = 32'd0;
    logic        resp_valid, resp_ready = 1'b0, resp_err, resp_timeout;
    logic [31:0] resp_rdata;
    logic        mem_valid, mem_instr, mem_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    logic        slv_init = 1'b1;
    logic [31:0] slv_mem [0:255];
    logic [7:0]  ref_mem [0:1023];
    int          vcnt = 0;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    dbg_mem_master #(.TIMEOUT(T)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .resp_timeout(resp_timeout),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] seed_word(input int i);
        return 32'(i) * 32'h9E3779B9 + 32'h12345678;
    endfunction

    assign mem_rdata = slv_mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (slv_init) begin
            for (int i = 0; i < 256; i++) slv_mem[i] <= seed_word(i);
        end else if (mem_valid && mem_ready) begin
            for (int k = 0; k < 4; k++)
                if (mem_wstrb[k]) slv_mem[mem_addr[9:2]][8*k +: 8] <= mem_wdata[8*k +: 8];
        end
        if (mem_valid) vcnt <= vcnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                           input logic [31:0] wd, input int delay, input int hold);
        logic        mis, ok, eerr, eto;
        logic [3:0]  estrb;
        logic [31:0] ewd, erd;
        int          n, v0, ecnt;
        mis   = sz == 2'd3 || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00);
        n     = mis ? 1 : (1 << sz);
        ok    = !mis && delay < T;
        eerr  = !ok;
        eto   = !mis && delay >= T;
        estrb = 4'b0;
        ewd   = 32'd0;
        erd   = 32'd0;
        for (int k = 0; k < 4; k++) ewd[8*k +: 8] = wd[8*(k % n) +: 8];
        if (wr && !mis) for (int k = 0; k < n; k++) estrb[int'(addr[1:0]) + k] = 1'b1;
        if (ok && !wr) for (int k = 0; k < n; k++) erd[8*k +: 8] = ref_mem[int'(addr[9:0]) + k];
        if (ok && wr) for (int k = 0; k < n; k++) ref_mem[int'(addr[9:0]) + k] = wd[8*k +: 8];
        ecnt = mis ? 0 : (delay + 1 < T ? delay + 1 : T);
        @(negedge clk);
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        v0        = vcnt;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_size  = sz;
        cmd_addr  = addr;
        cmd_wdata = wd;
        mem_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_size  = 2'($urandom);
        cmd_write = 1'($urandom);
        mem_ready = 1'b0;
        if (!mis) begin
            for (int i = 0; i < T && i <= delay; i++) begin
                chk("bus_valid", 32'(mem_valid), 32'd1);
                chk("bus_addr", mem_addr, {addr[31:2], 2'b00});
                chk("bus_wstrb", 32'(mem_wstrb), 32'(estrb));
                chk("bus_instr", 32'(mem_instr), 32'd0);
                chk("bus_cmd_ready", 32'(cmd_ready), 32'd0);
                chk("bus_resp_valid", 32'(resp_valid), 32'd0);
                if (wr) chk("bus_wdata", mem_wdata, ewd);
                mem_ready = (i == delay);
                @(negedge clk);
            end
            mem_ready = 1'b0;
        end
        chk("resp_mem_valid", 32'(mem_valid), 32'd0);
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_err", 32'(resp_err), 32'(eerr));
        chk("resp_timeout", 32'(resp_timeout), 32'(eto));
        chk("resp_rdata", resp_rdata, erd);
        chk("bus_cycles", 32'(vcnt - v0), 32'(ecnt));
        for (int h = 0; h < hold; h++) begin
            mem_ready = 1'($urandom_range(0, 1));
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_rdata", resp_rdata, erd);
            chk("hold_err", 32'(resp_err), 32'(eerr));
            chk("hold_timeout", 32'(resp_timeout), 32'(eto));
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("hold_mem_valid", 32'(mem_valid), 32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        mem_ready  = 1'b0;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("done_resp_valid", 32'(resp_valid), 32'd0);
        chk("done_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            for (int k = 0; k < 4; k++) ref_mem[4*i + k] = seed_word(i)[8*k +: 8];
        repeat (3) @(negedge clk);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_timeout", 32'(resp_timeout), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        slv_init = 1'b0;
        resetn   = 1'b1;
        run_cmd(1'b1, 2'd2, 32'h100, 32'hDEADBEEF, 1, 2);
        run_cmd(1'b0, 2'd2, 32'h100, 32'h0, 0, 0);
        run_cmd(1'b1, 2'd0, 32'h103, 32'h000000A5, 0, 1);
        run_cmd(1'b0, 2'd0, 32'h103, 32'h0, 2, 0);
        run_cmd(1'b0, 2'd1, 32'h101, 32'h0, 0, 1);
        run_cmd(1'b0, 2'd2, 32'h108, 32'h0, 20, 1);
        run_cmd(1'b1, 2'd1, 32'h10A, 32'h1234CAFE, T - 1, 0);
        run_cmd(1'b0, 2'd1, 32'h10A, 32'h0, T - 1, 5);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_size  = 2'd2;
        cmd_addr  = 32'h104;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rstbus_valid", 32'(mem_valid), 32'd1);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("rstbus_mem_valid", 32'(mem_valid), 32'd0);
        chk("rstbus_resp_valid", 32'(resp_valid), 32'd0);
        chk("rstbus_cmd_ready", 32'(cmd_ready), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("postrst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("postrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("postrst_mem_valid", 32'(mem_valid), 32'd0);
        run_cmd(1'b0, 2'd2, 32'h104, 32'h0, 1, 0);
        for (int r = 0; r < 40; r++)
            run_cmd(1'($urandom), 2'($urandom_range(0, 3)), 32'h100 + 32'($urandom_range(0, 63)),
                    $urandom, $urandom_range(0, 5), $urandom_range(0, 5));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dbg_mem_master.md
DBG_MEM_MASTER -- requirements
Module: dbg_mem_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 256, giving the max cycles mem_valid is held without mem_ready before abort (legal range 2..65535).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port resetn, input, 1, reset; synchronous, active-low.
REQ-004 SHALL have port cmd_valid, input, 1, debug command offered.
REQ-005 SHALL have port cmd_ready, output, 1, command accepted when cmd_valid && cmd_ready.
REQ-006 SHALL have port cmd_write, input, 1: 1 = write, 0 = read.
REQ-007 SHALL have port cmd_size, input, 2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-008 SHALL have port cmd_addr, input, 32, byte address.
REQ-009 SHALL have port cmd_wdata, input, 32, right-justified write data.
REQ-010 SHALL have port resp_valid, output, 1, response available.
REQ-011 SHALL have port resp_ready, input, 1, response consumed when resp_valid && resp_ready.
REQ-012 SHALL have port resp_rdata, output, 32, right-justified and zero-extended read data; 0 for writes and errors.
REQ-013 SHALL have port resp_err, output, 1, command failed (misaligned, illegal size or timeout).
REQ-014 SHALL have port resp_timeout, output, 1, failure was a bus timeout.
REQ-015 SHALL have ports mem_valid (output, 1), mem_instr (output, 1), mem_ready (input, 1), mem_addr (output, 32), mem_wdata (output, 32), mem_wstrb (output, 4) and mem_rdata (input, 32), forming the picorv32 native memory bus, initiator side.

Function
REQ-016 SHALL implement FSM IDLE -> BUS -> RESP -> IDLE; cmd_ready = (state == IDLE); resp_valid = (state == RESP).
REQ-017 SHALL, on accept of a command with bad alignment, go directly IDLE -> RESP with resp_err = 1 and resp_timeout = 0, issuing no bus cycle; bad alignment means half with addr[0] = 1, word with addr[1:0] != 0, or size 3.
REQ-018 SHALL, on accept of a legal command, enter BUS with registered mem_valid = 1 starting the next cycle.
REQ-019 SHALL drive mem_addr = {addr[31:2], 2'b00} and mem_instr = 0 throughout the bus cycle.
REQ-020 SHALL drive mem_wstrb = 0 on reads; on writes: byte 4'b0001 << addr[1:0], half 4'b0011 << addr[1:0], word 4'b1111.
REQ-021 SHALL drive mem_wdata as the byte replicated 4x, the half replicated 2x, or the full word.
REQ-022 SHALL hold mem_valid, mem_addr, mem_wdata and mem_wstrb stable until the cycle in which mem_ready = 1 is sampled, and SHALL ignore mem_ready while mem_valid = 0.
REQ-023 SHALL, on the cycle with mem_valid && mem_ready: capture (mem_rdata >> 8*addr[1:0]) masked to size (read only); deassert mem_valid next cycle; enter RESP with resp_err = 0.
REQ-024 SHALL count BUS cycles; when the count reaches TIMEOUT without mem_ready, it SHALL deassert mem_valid, enter RESP with resp_err = 1, resp_timeout = 1 and resp_rdata = 0.
REQ-025 SHALL treat mem_ready arriving in the same cycle the timeout is reached as success, not timeout.
REQ-026 SHALL hold resp_* stable in RESP until resp_ready; it SHALL return to IDLE the next cycle and assert cmd_ready then; back-to-back throughput SHALL be at most one command per 3 cycles.
REQ-027 SHALL give minimum latency (accept at cycle N, mem_ready immediate) of mem_valid at N+1 and resp_valid at N+2.

Reset
REQ-028 SHALL, while resetn = 0 at a clock edge, enter IDLE with mem_valid = 0, mem_wstrb = 0, mem_addr = 0, mem_wdata = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0, resp_timeout = 0, cmd_ready = 0 during reset, and the timeout counter at 0.
REQ-029 SHALL, on reset mid-transaction, drop mem_valid at that edge and discard the command with no response.

Structure
REQ-030 SHALL place the size encodings, FSM state enum and default TIMEOUT in shared package dbg_mem_pkg.
REQ-031 SHALL have lane steering (wstrb/wdata generation, rdata extraction) in combinational sub-module dbg_mem_lane.

Verification
REQ-032 SHALL verify: write word 0xDEADBEEF @0x100 then read @0x100 -> wstrb 1111, resp_rdata 0xDEADBEEF, resp_err 0.
REQ-033 SHALL verify: write byte 0xA5 @0x103 -> mem_addr 0x100, wstrb 1000, wdata 0xA5A5A5A5; read byte @0x103 -> 0x000000A5.
REQ-034 SHALL verify: read half @0x101 -> no mem_valid pulse, resp_err 1, resp_timeout 0, rdata 0.
REQ-035 SHALL verify: TIMEOUT = 4 with mem_ready held 0 -> mem_valid high exactly 4 cycles, resp_err 1, resp_timeout 1.
REQ-036 SHALL verify: pseudo-random mem_ready, resp_ready held 0 for 5 cycles -> bus signals stable until ready, resp held stable, cmd_ready 0 until consumed.
REQ-037 SHALL verify: resetn = 0 during BUS -> mem_valid 0 next edge, no resp_valid, next command completes normally.
